fp_result_normalizer: RTL and testbench
=======================================

FP_RESULT_NORMALIZER -- requirements
Module: fp_result_normalizer

Interface
REQ-001 The module SHALL have one parameter, FLUSH_SIGN, default 0: 0 forces +0 on zero/underflow results, 1 keeps the captured sign.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; rst=0 forces the reset state immediately.
REQ-004 start  input  1  request to accept one raw sum; sampled only in IDLE.
REQ-005 s_in  input  1  result sign from the adder datapath.
REQ-006 exp_in  input  8  biased result exponent, before normalization.
REQ-007 co_in  input  1  carry out of the mantissa add/subtract.
REQ-008 man_in  input  24  raw mantissa sum; bit 23 is the hidden-bit position.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  high exactly during the PACK cycle; result and flags are valid while done=1.
REQ-011 result  output  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}; held until the next PACK.
REQ-012 overflow  output  1  result saturated to infinity; held with result.
REQ-013 underflow  output  1  nonzero value flushed to zero; held with result.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CARRY, NORM, PACK.
REQ-015 Internal registers SHALL be sreg (1 bit), ereg (8 bits) and mreg (24 bits).
REQ-016 In IDLE with start=1, the block SHALL capture s_in, exp_in and man_in, then go to CARRY if co_in=1, else to NORM.
REQ-017 In IDLE with start=0, the block SHALL hold state, result and flags.
REQ-018 start SHALL be ignored in CARRY, NORM and PACK, with no queuing.
REQ-019 CARRY (one cycle), ereg=8'hFE or 8'hFF: load result={sreg,8'hFF,23'h0}, overflow=1, underflow=0, go to PACK.
REQ-020 CARRY, otherwise: load result={sreg, ereg+1, {1,mreg[23:1]}[22:0]} (shifted-out LSB truncated), both flags 0, go to PACK.
REQ-021 NORM SHALL apply these checks each cycle in priority order; the first match wins.
REQ-022 NORM check (a), ereg=8'hFF: load infinity with overflow=1, go to PACK.
REQ-023 NORM check (b), mreg=0 or ereg=0: load a zero result with both flags 0, go to PACK.
REQ-024 NORM check (c), mreg[23]=1: load {sreg, ereg, mreg[22:0]} with both flags 0, go to PACK.
REQ-025 NORM check (d), ereg=1: load a zero result with underflow=1, go to PACK.
REQ-026 NORM otherwise: mreg<=mreg<<1, ereg<=ereg-1, stay in NORM.
REQ-027 A zero result SHALL be {FLUSH_SIGN ? sreg : 0, 31'h0}.
REQ-028 PACK SHALL last one cycle with done=1, busy=1, then go to IDLE.
REQ-029 Latency SHALL be: done high in cycle 2+k after the start-sampling edge, where k = number of NORM shift cycles (k ≤ 23).
REQ-030 No rounding SHALL be performed; all discarded bits are truncated.
REQ-031 No denormal output SHALL ever be produced.

Reset
REQ-032 rst=0 SHALL asynchronously force state=IDLE, busy=0, done=0, result=32'h0, overflow=0, underflow=0, and clear sreg, ereg and mreg.
REQ-033 Reset mid-operation SHALL discard the in-flight operand, and no done SHALL follow.
REQ-034 After rst returns to 1, the first start SHALL be accepted on the next rising edge.

Verification
REQ-035 Reset: drive rst=0 during NORM with k pending -> busy, done, result and flags all go 0 without waiting for a clock edge; no later done.
REQ-036 Already normalized: s=0, exp=8'h7F, co=0, man=24'h800000 -> done 2 cycles after start, result=32'h3F800000, flags 0.
REQ-037 Carry: s=0, exp=8'h7F, co=1, man=24'h000000 -> done 2 cycles after start, result=32'h40000000.
REQ-038 Left shift: s=1, exp=8'h80, co=0, man=24'h200000 -> done 4 cycles after start, result=32'hBF000000; a start pulse during busy is ignored.
REQ-039 Overflow: exp=8'hFE, co=1, man=24'hFFFFFF, s=0 -> result=32'h7F800000, overflow=1, done 2 cycles after start.
REQ-040 Underflow and zero: exp=8'h02, co=0, man=24'h000001 -> one shift, then result=32'h0, underflow=1 (done 3 cycles after start); exp=8'h50, man=0 -> result=32'h0, underflow=0.

Source files
------------

// File: rtl/fp_result_normalizer.sv
// Post-add normalizer for IEEE-754 single precision: carry right-shift or
// leading-zero left-shift one bit per cycle, then pack with saturate/flush.
module fp_result_normalizer #(
    parameter bit FLUSH_SIGN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_in,
    input  logic [7:0]  exp_in,
    input  logic        co_in,
    input  logic [23:0] man_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARRY = 2'd1,
        NORM  = 2'd2,
        PACK  = 2'd3
    } state_t;

    state_t      state, state_d;
    logic        sreg, sreg_d;
    logic [7:0]  ereg, ereg_d;
    logic [23:0] mreg, mreg_d;
    logic [31:0] result_d;
    logic        overflow_d, underflow_d;

    logic [7:0]  ereg_inc;
    logic [7:0]  ereg_dec;
    logic [31:0] zero_word;
    logic [31:0] inf_word;

    assign ereg_inc  = ereg + 8'd1;
    assign ereg_dec  = ereg - 8'd1;
    // Signed zero only survives when FLUSH_SIGN is set; otherwise zero is always +0.
    assign zero_word = {(FLUSH_SIGN ? sreg : 1'b0), 31'h0};
    assign inf_word  = {sreg, 8'hFF, 23'h0};

    assign busy = (state != IDLE);
    assign done = (state == PACK);

    always_comb begin
        state_d     = state;
        sreg_d      = sreg;
        ereg_d      = ereg;
        mreg_d      = mreg;
        result_d    = result;
        overflow_d  = overflow;
        underflow_d = underflow;

        unique case (state)
            IDLE: begin
                if (start) begin
                    sreg_d  = s_in;
                    ereg_d  = exp_in;
                    mreg_d  = man_in;
                    state_d = co_in ? CARRY : NORM;
                end
            end

            CARRY: begin
                if (ereg >= 8'hFE) begin
                    result_d    = inf_word;
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                end else begin
                    // Carry supplies the new hidden bit; old bit 0 is dropped.
                    result_d    = {sreg, ereg_inc, mreg[23:1]};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end
                state_d = PACK;
            end

            NORM: begin
                if (ereg == 8'hFF) begin
                    result_d    = inf_word;
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                    state_d     = PACK;
                end else if (mreg == 24'h0 || ereg == 8'h00) begin
                    result_d    = zero_word;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = PACK;
                end else if (mreg[23]) begin
                    result_d    = {sreg, ereg, mreg[22:0]};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = PACK;
                end else if (ereg == 8'h01) begin
                    // One more shift would need a denormal: flush instead.
                    result_d    = zero_word;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b1;
                    state_d     = PACK;
                end else begin
                    mreg_d = {mreg[22:0], 1'b0};
                    ereg_d = ereg_dec;
                end
            end

            PACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= 1'b0;
            ereg      <= '0;
            mreg      <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            ereg      <= ereg_d;
            mreg      <= mreg_d;
            result    <= result_d;
            overflow  <= overflow_d;
            underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fp_result_normalizer.sv
// Directed bench for fp_result_normalizer: latency, packing, saturation,
// flush-to-zero, ignored start pulses and asynchronous reset.
module tb_fp_result_normalizer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_in;
    logic [7:0]  exp_in;
    logic        co_in;
    logic [23:0] man_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int unsigned checks;
    int unsigned failures;

    fp_result_normalizer #(.FLUSH_SIGN(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_in      (s_in),
        .exp_in    (exp_in),
        .co_in     (co_in),
        .man_in    (man_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negedge; the start edge is the next posedge.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic co, input logic [23:0] m,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_ovf, input logic exp_unf,
                          input bit pulse);
        int cyc;
        s_in   = s;
        exp_in = e;
        co_in  = co;
        man_in = m;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (pulse && cyc == 1) begin
                start  = 1'b1;
                s_in   = 1'b0;
                exp_in = 8'h7F;
                co_in  = 1'b1;
                man_in = 24'h123456;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, exp_ovf});
        check({tag, "_unf"}, {31'h0, underflow}, {31'h0, exp_unf});
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
        check({tag, "_hold"}, result, exp_res);
        @(negedge clk);
    endtask

    initial begin
        int done_seen;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        s_in      = 1'b0;
        exp_in    = '0;
        co_in     = 1'b0;
        man_in    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_unf", {31'h0, underflow}, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // start=0 in IDLE leaves everything untouched
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", {29'h0, busy, done, overflow}, 32'h0);
        @(negedge clk);

        run_op("norm",     1'b0, 8'h7F, 1'b0, 24'h800000, 2, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        run_op("carry",    1'b0, 8'h7F, 1'b1, 24'h000000, 2, 32'h40000000, 1'b0, 1'b0, 1'b0);
        run_op("shift",    1'b1, 8'h80, 1'b0, 24'h200000, 4, 32'hBF000000, 1'b0, 1'b0, 1'b1);
        run_op("ovf",      1'b0, 8'hFE, 1'b1, 24'hFFFFFF, 2, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        run_op("unf",      1'b0, 8'h02, 1'b0, 24'h000001, 3, 32'h00000000, 1'b0, 1'b1, 1'b0);
        run_op("zero",     1'b0, 8'h50, 1'b0, 24'h000000, 2, 32'h00000000, 1'b0, 1'b0, 1'b0);
        run_op("carry2",   1'b1, 8'h80, 1'b1, 24'hC00001, 2, 32'hC0E00000, 1'b0, 1'b0, 1'b0);
        run_op("negzero",  1'b1, 8'h40, 1'b0, 24'h000000, 2, 32'h00000000, 1'b0, 1'b0, 1'b0);
        run_op("exp0",     1'b1, 8'h00, 1'b0, 24'h400000, 2, 32'h00000000, 1'b0, 1'b0, 1'b0);
        run_op("carry_ff", 1'b0, 8'hFF, 1'b1, 24'h000000, 2, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        run_op("norm_ff",  1'b1, 8'hFF, 1'b0, 24'h000001, 2, 32'hFF800000, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a long shift sequence
        s_in   = 1'b0;
        exp_in = 8'h80;
        co_in  = 1'b0;
        man_in = 24'h000001;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        check("arst_result", result, 32'h0);
        check("arst_ovf", {31'h0, overflow}, 32'h0);
        check("arst_unf", {31'h0, underflow}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("no_done_after_rst", done_seen, 32'h0);

        // First start right after reset release is accepted on the next edge
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst", 1'b0, 8'h7F, 1'b0, 24'h800000, 2, 32'h3F800000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
